flash_id_uart_report: RTL and testbench



---
 rtl/flash_report_pkg.sv | 47 ++++
 rtl/uart_byte_tx.sv | 123 ++++++++++++
 rtl/flash_id_uart_report.sv | 94 +++++++++
 tb/tb_flash_id_uart_report.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/flash_report_pkg.sv
// Shared constants, transmitter state encoding and ASCII helpers for the
// flash-ID UART report path.
package flash_report_pkg;

    localparam logic [7:0] ASC_I     = 8'h49;
    localparam logic [7:0] ASC_D     = 8'h44;
    localparam logic [7:0] ASC_COLON = 8'h3A;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;

    localparam int unsigned MSG_LEN  = 32'd7;
    localparam logic [2:0]  MSG_LAST = 3'(MSG_LEN - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] nibble2ascii(input logic [3:0] nib);
        logic [7:0] res_s;
        if (nib <= 4'd9) begin
            res_s = 8'h30 + {4'h0, nib};
        end else begin
            res_s = 8'h37 + {4'h0, nib};
        end
        return res_s;
    endfunction

    // Byte idx of the line "ID:XX\r\n" for a given ID.
    function automatic logic [7:0] msg_byte(input logic [2:0] idx, input logic [7:0] id);
        logic [7:0] res_s;
        case (idx)
            3'd0:    res_s = ASC_I;
            3'd1:    res_s = ASC_D;
            3'd2:    res_s = ASC_COLON;
            3'd3:    res_s = nibble2ascii(id[7:4]);
            3'd4:    res_s = nibble2ascii(id[3:0]);
            3'd5:    res_s = ASC_CR;
            3'd6:    res_s = ASC_LF;
            default: res_s = ASC_LF;
        endcase
        return res_s;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte transmitter. A request seen in the final stop-bit cycle chains the
// next frame with no idle gap; tx_done marks that final stop-bit cycle.
module uart_byte_tx
    import flash_report_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 32'd434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    if (BAUD_DIV < 32'd2) begin : g_baud_chk
        $error("uart_byte_tx: BAUD_DIV must be >= 2");
    end

    localparam int unsigned     CNT_W     = (BAUD_DIV > 32'd2) ? $clog2(BAUD_DIV) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(32'd0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 32'd1);
    localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(BAUD_DIV - 32'd2);

    tx_state_e        state_r;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             tx_r;
    logic             busy_r;
    logic             done_r;
    logic             baud_end_s;

    // Last cycle of the current bit period
    always_comb begin
        baud_end_s = (baud_cnt_r == BAUD_LAST);
    end

    // Frame sequencer: start bit, eight data bits LSB first, stop bit
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= CNT_ZERO;
                    if (tx_start) begin
                        state_r   <= ST_START;
                        shift_r   <= tx_data;
                        bit_cnt_r <= 3'd0;
                        tx_r      <= 1'b0;
                        busy_r    <= 1'b1;
                    end else begin
                        tx_r   <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= CNT_ZERO;
                        state_r    <= ST_DATA;
                        tx_r       <= shift_r[0];
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= CNT_ZERO;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    // Pre-decoded one cycle early so tx_done is a clean register
                    done_r <= (baud_cnt_r == BAUD_PRE);
                    if (baud_end_s) begin
                        baud_cnt_r <= CNT_ZERO;
                        if (tx_start) begin
                            state_r   <= ST_START;
                            shift_r   <= tx_data;
                            bit_cnt_r <= 3'd0;
                            tx_r      <= 1'b0;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= CNT_ZERO;
                    tx_r       <= 1'b1;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    assign tx      = tx_r;
    assign tx_busy = busy_r;
    assign tx_done = done_r;

endmodule

// File: rtl/flash_id_uart_report.sv
// Reports the flash ID as the ASCII line "ID:XX\r\n" on a UART pin, once per
// rising edge of the ID-valid flag; edges during a report are dropped.
module flash_id_uart_report
    import flash_report_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 32'd50_000_000,
    parameter int unsigned BAUD     = 32'd115_200,
    parameter int unsigned BAUD_DIV = CLK_FREQ / BAUD
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       id_flag,
    input  logic [7:0] flash_id,
    output logic       uart_tx,
    output logic       busy,
    output logic       done
);

    logic       id_flag_d_r;
    logic [7:0] id_reg_r;
    logic [2:0] byte_idx_r;
    logic       busy_r;
    logic       done_r;
    logic       start_s;
    logic       tx_start_s;
    logic [7:0] tx_data_s;
    logic       tx_busy_s;
    logic       tx_done_s;

    // Rising edge of the ID-valid flag
    always_comb begin
        start_s = id_flag & ~id_flag_d_r;
    end

    // First byte launches from idle; later bytes chain in the final stop-bit cycle
    always_comb begin
        tx_start_s = 1'b0;
        tx_data_s  = ASC_I;
        if (!busy_r) begin
            tx_start_s = start_s & ~tx_busy_s;
            tx_data_s  = ASC_I;
        end else if (tx_done_s && (byte_idx_r != MSG_LAST)) begin
            tx_start_s = 1'b1;
            tx_data_s  = msg_byte(byte_idx_r + 3'd1, id_reg_r);
        end else begin
            tx_start_s = 1'b0;
            tx_data_s  = ASC_I;
        end
    end

    // Message sequencing, ID capture and the report status outputs
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            id_flag_d_r <= 1'b0;
            id_reg_r    <= 8'h00;
            byte_idx_r  <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            id_flag_d_r <= id_flag;
            done_r      <= 1'b0;
            if (!busy_r) begin
                if (tx_start_s) begin
                    busy_r     <= 1'b1;
                    id_reg_r   <= flash_id;
                    byte_idx_r <= 3'd0;
                end
            end else if (tx_done_s) begin
                if (byte_idx_r == MSG_LAST) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    byte_idx_r <= byte_idx_r + 3'd1;
                end
            end
        end
    end

    uart_byte_tx #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte_tx (
        .clk      (sys_clk),
        .rst      (sys_rst),
        .tx_start (tx_start_s),
        .tx_data  (tx_data_s),
        .tx_busy  (tx_busy_s),
        .tx_done  (tx_done_s),
        .tx       (uart_tx)
    );

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_flash_id_uart_report.sv
// Directed bench for flash_id_uart_report at BAUD_DIV = 10.
module tb_flash_id_uart_report;

    logic       sys_clk;
    logic       sys_rst;
    logic       id_flag;
    logic [7:0] flash_id;
    logic       uart_tx;
    logic       busy;
    logic       done;

    int n_assert = 0;
    int n_fail   = 0;

    flash_id_uart_report #(
        .CLK_FREQ (32'd1_000_000),
        .BAUD     (32'd100_000)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .id_flag  (id_flag),
        .flash_id (flash_id),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .done     (done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Raise the flag at a negedge; the start bit must be on the line one cycle later.
    task automatic launch(input logic [7:0] id);
        flash_id = id;
        id_flag  = 1'b1;
        check("pre_start_tx", uart_tx, 1);
        @(negedge sys_clk);
        check("start_tx", uart_tx, 0);
        check("start_busy", busy, 1);
        check("start_done", done, 0);
    endtask

    // Entered on the first start-bit cycle; decodes 7 frames sampling every cycle.
    task automatic capture(input int drop_cyc, input int rise_cyc, input int rst_cyc,
                           input logic [7:0] rise_id, output logic [55:0] msg, output bit aborted);
        logic [9:0] frame;
        bit stable_ok, frame_ok, busy_ok, done_ok;
        int cyc;
        msg = 56'h0; aborted = 1'b0; frame = 10'h0;
        stable_ok = 1'b1; frame_ok = 1'b1; busy_ok = 1'b1; done_ok = 1'b1; cyc = 0;
        for (int b = 0; b < 7; b++) begin
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < 10; c++) begin
                    if (c == 0) frame[k] = uart_tx;
                    else if (uart_tx !== frame[k]) stable_ok = 1'b0;
                    if (busy !== 1'b1) busy_ok = 1'b0;
                    if (done !== 1'b0) done_ok = 1'b0;
                    if (cyc == drop_cyc) id_flag = 1'b0;
                    if (cyc == rise_cyc) begin
                        id_flag  = 1'b1;
                        flash_id = rise_id;
                    end
                    if (cyc == rst_cyc) begin
                        sys_rst = 1'b1;
                        @(negedge sys_clk);
                        check("rst_tx", uart_tx, 1);
                        check("rst_busy", busy, 0);
                        check("rst_done", done, 0);
                        sys_rst = 1'b0;
                        aborted = 1'b1;
                        return;
                    end
                    cyc++;
                    @(negedge sys_clk);
                end
            end
            if (frame[0] !== 1'b0 || frame[9] !== 1'b1) frame_ok = 1'b0;
            msg = {msg[47:0], frame[8:1]};
        end
        check("bit_timing", stable_ok, 1);
        check("framing", frame_ok, 1);
        check("busy_span", busy_ok, 1);
        check("no_early_done", done_ok, 1);
    endtask

    task automatic end_checks();
        check("done_pulse", done, 1);
        check("end_busy", busy, 0);
        check("end_tx", uart_tx, 1);
    endtask

    task automatic after_done();
        @(negedge sys_clk);
        check("done_single", done, 0);
    endtask

    task automatic count_busy(input int cycles, output int hits);
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || uart_tx !== 1'b1) hits++;
            @(negedge sys_clk);
        end
    endtask

    initial begin
        logic [55:0] msg;
        bit          ab;
        int          hits;

        sys_rst = 1'b1; id_flag = 1'b0; flash_id = 8'h00;
        repeat (3) @(negedge sys_clk);
        check("reset_tx", uart_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        sys_rst = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("idle_tx", uart_tx, 1);
        check("idle_busy", busy, 0);

        // Basic report, flag held high throughout
        launch(8'hEF);
        capture(-1, -1, -1, 8'h00, msg, ab);
        check("msg_EF", msg, 56'h49443A45460D0A);
        end_checks();
        after_done();
        id_flag = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Nibble boundaries; the second report is launched in the done cycle
        launch(8'h09);
        capture(5, -1, -1, 8'h00, msg, ab);
        check("msg_09", msg, 56'h49443A30390D0A);
        end_checks();
        launch(8'hA0);
        capture(5, -1, -1, 8'h00, msg, ab);
        check("msg_A0", msg, 56'h49443A41300D0A);
        end_checks();
        after_done();

        // New edge with changed ID during a report is ignored
        launch(8'h5C);
        capture(5, 200, -1, 8'h11, msg, ab);
        check("msg_ignored_edge", msg, 56'h49443A35430D0A);
        end_checks();
        after_done();
        count_busy(30, hits);
        check("no_requeue", hits, 0);
        id_flag = 1'b0;
        repeat (3) @(negedge sys_clk);

        // Reset mid-report abandons the frame; a later report is complete
        launch(8'h3B);
        capture(5, -1, 350, 8'h00, msg, ab);
        check("aborted", ab, 1);
        count_busy(20, hits);
        check("quiet_after_rst", hits, 0);
        launch(8'hC4);
        capture(5, -1, -1, 8'h00, msg, ab);
        check("msg_C4", msg, 56'h49443A43340D0A);
        end_checks();
        after_done();

        // Flag high through reset release counts as an edge, once
        sys_rst = 1'b1; id_flag = 1'b1; flash_id = 8'h7E;
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("held_pre_tx", uart_tx, 1);
        @(negedge sys_clk);
        check("held_start_tx", uart_tx, 0);
        check("held_start_busy", busy, 1);
        capture(-1, -1, -1, 8'h00, msg, ab);
        check("msg_7E_held", msg, 56'h49443A37450D0A);
        end_checks();
        after_done();
        count_busy(50, hits);
        check("held_no_repeat", hits, 0);
        id_flag = 1'b0;
        repeat (2) @(negedge sys_clk);
        launch(8'h7E);
        capture(5, -1, -1, 8'h00, msg, ab);
        check("msg_7E_again", msg, 56'h49443A37450D0A);
        end_checks();
        after_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
